// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned, with div-by-zero and overflow shortcuts
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sdiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [3:0]       DivFlags
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_q, r_rem, r_bm, r_quot, r_remd;
  logic [3:0] r_flags;
  logic r_neg_q, r_neg_r, r_c, r_v, r_done;
  logic w_a_neg, w_b_neg, w_div0, w_ovf, w_ge;
  logic [WIDTH:0] w_shift;
  logic [WIDTH-1:0] w_sub;
  assign w_a_neg = sdiv & a[WIDTH-1];
  assign w_b_neg = sdiv & b[WIDTH-1];
  assign w_div0  = b == '0;
  assign w_ovf   = sdiv && a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
  // r_q starts as the dividend magnitude and shifts quotient bits in from the bottom
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_bm};
  assign w_sub   = w_shift[WIDTH-1:0] - r_bm;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (start ? ((w_div0 || w_ovf) ? DONE : CALC) : IDLE) :
             r_state == CALC ? (r_cnt == CW'(WIDTH - 1) ? FIX : CALC) :
             r_state == FIX  ? DONE : IDLE;
  always_comb begin
    busy      = r_state != IDLE;
    done      = r_done;
    Quotient  = r_quot;
    Remainder = r_remd;
    DivFlags  = r_flags;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_bm    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_flags <= '0;
    end else begin
      r_done <= r_state == DONE;
      if (r_state == IDLE && start) begin
        r_q     <= w_div0 ? '1 : w_ovf ? a : w_a_neg ? -a : a;
        r_rem   <= w_div0 ? a : '0;
        r_bm    <= w_b_neg ? -b : b;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_c     <= w_div0;
        r_v     <= w_ovf;
        r_cnt   <= '0;
      end
      if (r_state == CALC) begin
        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIX) begin
        r_q   <= r_neg_q ? -r_q : r_q;
        r_rem <= r_neg_r ? -r_rem : r_rem;
      end
      if (r_state == DONE) begin
        r_quot  <= r_q;
        r_remd  <= r_rem;
        r_flags <= {r_q[WIDTH-1], r_q == '0, r_c, r_v};
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, randomized ops against an arithmetic model, and reset/busy corner sequences
module tb_seq_divider;
  logic clk = 0, reset = 1, start = 0, sdiv = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] Quotient, Remainder;
  logic [3:0] DivFlags;
  int n_vec = 0, n_err = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sdiv(sdiv), .a(a), .b(b),
    .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder), .DivFlags(DivFlags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic s;
    logic [31:0] q, r;
    logic [3:0] f;
    int lat;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic [3:0] f, output int lat);
    logic c, v;
    c = 0; v = 0; lat = 34;
    if (ib == 0) begin
      q = '1; r = ia; c = 1; lat = 1;
    end else if (is && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
      q = ia; r = 0; v = 1; lat = 1;
    end else if (is) begin
      q = 32'($signed(ia) / $signed(ib));
      r = 32'($signed(ia) % $signed(ib));
    end else begin
      q = ia / ib;
      r = ia % ib;
    end
    f = {q[31], q == 0, c, v};
  endfunction

  task automatic do_op(input string nm, input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [31:0] eq, input logic [31:0] er, input logic [3:0] ef, input int el);
    int lat;
    logic bsy;
    @(negedge clk);
    a = ia; b = ib; sdiv = is; start = 1;
    @(negedge clk);
    start = 0; a = ~ia; b = ib ^ 32'h5A5A_0001; sdiv = ~is;
    bsy = busy; lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    chk({nm, " busy"}, 32'(bsy), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " quotient"}, Quotient, eq);
    chk({nm, " remainder"}, Remainder, er);
    chk({nm, " flags"}, 32'(DivFlags), 32'(ef));
    @(negedge clk);
    chk({nm, " done width"}, 32'(done), 32'd0);
    chk({nm, " hold"}, Quotient, eq);
  endtask

  initial begin
    logic [31:0] eq, er, ra, rb;
    logic [3:0] ef;
    logic rs;
    int el, dn;
    tbl[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0000, 34};
    tbl[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 34};
    tbl[2]  = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 4'b1010, 1};
    tbl[3]  = '{32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 4'b1010, 1};
    tbl[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 4'b1001, 1};
    tbl[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 4'b0100, 34};
    tbl[6]  = '{32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 4'b0100, 34};
    tbl[7]  = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 4'b1000, 34};
    tbl[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'b0000, 34};
    tbl[9]  = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 4'b1000, 34};
    tbl[10] = '{32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 4'b1000, 34};
    tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 4'b0000, 34};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset quotient", Quotient, 0);
    chk("reset remainder", Remainder, 0);
    chk("reset flags", 32'(DivFlags), 0);
    reset = 0;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].f, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rs = 1'(($urandom) & 1);
      rb = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1; end
        2: rb = $urandom_range(1, 15);
        default: ;
      endcase
      model(ra, rb, rs, eq, er, ef, el);
      do_op($sformatf("rand%0d", i), ra, rb, rs, eq, er, ef, el);
    end

    // back-to-back: second start issued in the cycle right after done
    @(negedge clk);
    a = 32'd1000; b = 32'd10; sdiv = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("b2b first quotient", Quotient, 32'd100);
    a = 32'd77; b = 32'd8; start = 1;
    @(negedge clk);
    start = 0;
    chk("b2b second busy", 32'(busy), 1);
    dn = -1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin dn = i; break; end
      @(negedge clk);
    end
    chk("b2b second latency", 32'(dn), 32'd34);
    chk("b2b second quotient", Quotient, 32'd9);
    chk("b2b second remainder", Remainder, 32'd5);

    // start while busy is ignored
    @(negedge clk);
    a = 32'd50; b = 32'd5; sdiv = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    a = 32'd0; b = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        dn++;
        if (dn == 1) begin
          chk("busy-start quotient", Quotient, 32'd10);
          chk("busy-start remainder", Remainder, 32'd0);
        end
      end
      @(negedge clk);
    end
    chk("busy-start done count", 32'(dn), 32'd1);

    // reset mid-division aborts without done
    a = 32'd100; b = 32'd7; sdiv = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort quotient", Quotient, 0);
    chk("abort remainder", Remainder, 0);
    chk("abort flags", 32'(DivFlags), 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort no done", 32'(dn), 0);
    do_op("after abort", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 4'b0000, 34);

    // reset wins over a simultaneous start
    a = 32'd9; b = 32'd3; start = 1; reset = 1;
    @(negedge clk);
    start = 0; reset = 0;
    chk("reset vs start busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("reset vs start idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port sdiv  input  1  1 = signed (SDIV), 0 = unsigned (UDIV); latched at start.
REQ-006 SHALL have port a  input  WIDTH  dividend, latched at start.
REQ-007 SHALL have port b  input  WIDTH  divisor, latched at start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port Quotient  output  WIDTH  quotient result.
REQ-011 SHALL have port Remainder  output  WIDTH  remainder result.
REQ-012 SHALL have port DivFlags  output  4  {N, Z, C, V} status for the completed operation.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with start=1, latch a, b and sdiv, and go to CALC; if the divisor is zero or the operation is a signed overflow, it SHALL go directly to DONE.
REQ-015 SHALL, in CALC, run a radix-2 restoring division on operand magnitudes for exactly WIDTH cycles, producing one quotient bit per cycle, MSB first.
REQ-016 SHALL, in FIX, negate the quotient when sdiv=1 and the operand signs differ, and negate the remainder when sdiv=1 and the dividend is negative, then go to DONE.
REQ-017 SHALL, in DONE, assert done for exactly one cycle, update Quotient, Remainder and DivFlags in that same cycle, then return to IDLE.
REQ-018 SHALL hold latency at WIDTH+2 cycles: with start sampled at edge k, done is high in the cycle following edge k+WIDTH+2.
REQ-019 SHALL assert busy in CALC, FIX and DONE, and deassert it in IDLE.
REQ-020 SHALL ignore start whenever the FSM is not in IDLE; operands latched earlier SHALL be unaffected.
REQ-021 SHALL round signed results toward zero, with the remainder taking the sign of the dividend; a = Q*b + R SHALL hold for every non-exceptional case.
REQ-022 SHALL handle divide-by-zero (b==0) with latency 1: done one cycle after start, Quotient = all ones, Remainder = a, C=1.
REQ-023 SHALL handle signed overflow (sdiv=1, a=MSB-only, b=all ones) with latency 1: Quotient = a, Remainder = 0, V=1.
REQ-024 SHALL set N = Quotient[WIDTH-1] and Z = (Quotient==0); C and V SHALL be 0 except as defined in REQ-022 and REQ-023.
REQ-025 SHALL hold Quotient, Remainder and DivFlags stable from the done cycle until the next done.
REQ-026 SHALL accept a new start in the cycle immediately after done (back-to-back operation).

Reset
REQ-027 SHALL, when reset=1 at a rising edge, force the FSM to IDLE and clear busy, done, Quotient, Remainder and DivFlags to 0, in any state.
REQ-028 SHALL abort an operation interrupted by reset without any done pulse; reset SHALL take priority over a simultaneous start.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> Quotient=14, Remainder=2, DivFlags=0000, done exactly 34 cycles after start.
REQ-030 SHALL cover: signed -7/2 (0xFFFFFFF9/0x00000002) -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF, N=1.
REQ-031 SHALL cover: 5/0 (either mode) -> done after 1 cycle, Quotient=0xFFFFFFFF, Remainder=5, C=1.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0, V=1, N=1, latency 1.
REQ-033 SHALL cover: start with 0/3 while busy from a prior 50/5 -> only 50/5 completes (Quotient=10, Remainder=0), and no second done occurs.
REQ-034 SHALL cover: reset asserted 10 cycles into a division -> busy=0 and all outputs 0 next cycle, no done, and a following 9/3 returns Quotient=3.
